// File: rtl/aes_ctrl_if.sv
// Request/response bundle between a requester and the AES controller.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface aes_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;

    // Requester side: issues plaintext/key, consumes ciphertext.
    modport master (
        output in_valid, pt, key, out_ready,
        input  in_ready, out_valid, ct
    );

    // Controller side.
    modport slave (
        input  in_valid, pt, key, out_ready,
        output in_ready, out_valid, ct
    );
endinterface

// File: rtl/aes_ctrl.sv
// AES core sequencer: loads pt/key as 32-bit words, waits for core_done, reads 4 ct words back.
// Latency: 9 load + W wait + 1 read request + 1 gap + 4 read cycles from accept to out_valid.
// Backpressure: one request in flight; in_ready only in IDLE, result held until out_ready. Option: AES_CTRL_TIMEOUT_EN.
module aes_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    aes_ctrl_if.slave   bus,
    output logic        busy,
    output logic        err,
    output logic        core_start_n,
    output logic        core_start_read_n,
    output logic [31:0] core_dword_in,
    input  logic [31:0] core_dword_out,
    input  logic        core_done
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, RDREQ, GAP, READ, OUT} state_t;

    state_t       state;
    state_t       nstate;
    logic [3:0]   idx;        // load word index L0..L8
    logic [1:0]   ridx;       // read word index
    logic [127:0] pt_q;
    logic [127:0] key_q;
    logic [127:0] ct_q;
    logic         armed;      // holds in_ready low until the first clock out of reset
    logic         tmo_hit;
    logic [31:0]  load_word;
    logic         accept;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (state == IDLE) && armed;
    assign bus.out_valid = (state == OUT);
    assign bus.ct        = ct_q;
    assign busy          = (state != IDLE);

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int TCW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tmo_cnt;
    logic           err_q;

    // Count consecutive WAIT cycles; a timeout abort is flagged for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
            err_q   <= tmo_hit;
        end
    end

    assign err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign err        = 1'b0;
`endif

    // Word presented to the core at each load index; pt word 0 is repeated across the start strobe.
    always_comb begin
        load_word = 32'h0;
        case (idx)
            4'd0, 4'd1: load_word = pt_q[127:96];
            4'd2:       load_word = pt_q[95:64];
            4'd3:       load_word = pt_q[63:32];
            4'd4:       load_word = pt_q[31:0];
            4'd5:       load_word = key_q[127:96];
            4'd6:       load_word = key_q[95:64];
            4'd7:       load_word = key_q[63:32];
            4'd8:       load_word = key_q[31:0];
            default:    load_word = 32'h0;
        endcase
    end

    // State register; reset lands in IDLE from anywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    // Next state and core strobes; strobes idle high and only one is ever asserted.
    always_comb begin
        nstate            = state;
        core_start_n      = 1'b1;
        core_start_read_n = 1'b1;
        core_dword_in     = 32'h0;
        tmo_hit           = 1'b0;
        case (state)
            IDLE: if (accept) nstate = LOAD;
            LOAD: begin
                core_start_n  = (idx != 4'd0);
                core_dword_in = load_word;
                if (idx == 4'd8) nstate = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    nstate = RDREQ;
                end
`ifdef AES_CTRL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    nstate  = IDLE;
                    tmo_hit = 1'b1;
                end
`endif
            end
            RDREQ: begin
                core_start_read_n = 1'b0;
                nstate            = GAP;
            end
            GAP:  nstate = READ;
            READ: if (ridx == 2'd3) nstate = OUT;
            OUT:  if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Request capture, word indices and ciphertext assembly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
            pt_q  <= '0;
            key_q <= '0;
            ct_q  <= '0;
            idx   <= '0;
            ridx  <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                pt_q  <= bus.pt;
                key_q <= bus.key;
            end
            idx  <= (state == LOAD) ? idx + 4'd1 : 4'd0;
            ridx <= (state == READ) ? ridx + 2'd1 : 2'd0;
            if (state == READ) begin
                case (ridx)
                    2'd0: ct_q[127:96] <= core_dword_out;
                    2'd1: ct_q[95:64]  <= core_dword_out;
                    2'd2: ct_q[63:32]  <= core_dword_out;
                    2'd3: ct_q[31:0]   <= core_dword_out;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_ctrl.sv
// Directed bench for aes_ctrl with a small AES core stand-in returning a known ciphertext.
// Latency: checks accept-to-out_valid cycle count against 15 + wait cycles.
// Backpressure: holds out_ready low for several cycles and checks the result stays put.
module tb_aes_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy, err;
    logic        core_start_n, core_start_read_n, core_done;
    logic [31:0] core_dword_in, core_dword_out;

    always #5 clk = ~clk;

    aes_ctrl_if bus ();

    aes_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .busy              (busy),
        .err               (err),
        .core_start_n      (core_start_n),
        .core_start_read_n (core_start_read_n),
        .core_dword_in     (core_dword_in),
        .core_dword_out    (core_dword_out),
        .core_done         (core_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Core stand-in: records load words, raises core_done after done_delay WAIT cycles, returns core_ct.
    logic [127:0] core_ct;
    int           done_delay;
    logic [31:0]  ld_w [9];
    int           ld_cnt, wait_cnt, rd_ph;
    bit           wait_arm;
    int           strobe_clash = 0;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_cnt         = 0;
            wait_arm       = 0;
            wait_cnt       = 0;
            rd_ph          = 0;
            core_done      = 1'b0;
            core_dword_out = 32'h0;
        end else begin
            if (!core_start_n && !core_start_read_n) strobe_clash++;
            if (wait_arm) begin
                if (wait_cnt <= 1) begin
                    core_done = 1'b1;
                    wait_arm  = 0;
                end else begin
                    wait_cnt--;
                end
            end
            if (!core_start_n) begin
                ld_w[0] = core_dword_in;
                ld_cnt  = 1;
            end else if (ld_cnt >= 1 && ld_cnt <= 8) begin
                ld_w[ld_cnt] = core_dword_in;
                ld_cnt++;
                if (ld_cnt == 9) begin
                    if (done_delay == 0) core_done = 1'b1;
                    else if (done_delay > 0) begin
                        wait_arm = 1;
                        wait_cnt = done_delay;
                    end
                end
            end
            if (!core_start_read_n) begin
                core_done = 1'b0;
                rd_ph     = 1;
            end else if (rd_ph >= 1 && rd_ph <= 5) begin
                if (rd_ph >= 2) core_dword_out = core_ct[127-32*(rd_ph-2) -: 32];
                rd_ph++;
            end
        end
    end

    function automatic logic [31:0] exp_load(input logic [127:0] p, input logic [127:0] k, input int j);
        if (j < 2)      return p[127:96];
        else if (j < 5) return p[127-32*(j-1) -: 32];
        else            return k[127-32*(j-5) -: 32];
    endfunction

    task automatic wait_ready(input string tag);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("%s in_ready", tag), 128'(got), 128'(1));
    endtask

    // Full request: w is the expected number of WAIT cycles, hold the out_ready stall length.
    task automatic do_req(input string tag, input logic [127:0] p, input logic [127:0] k,
                          input logic [127:0] c, input int d, input int w, input int hold,
                          input bit toggle);
        int lat;
        bit got, stable;
        logic [127:0] ct_seen;
        wait_ready(tag);
        bus.pt = p; bus.key = k; core_ct = c; done_delay = d; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_valid) begin
                got = 1;
                break;
            end
            if (lat == 0) chk($sformatf("%s start_n L0", tag), 128'(core_start_n), 128'(0));
            if (lat == 1) chk($sformatf("%s in_ready busy", tag), 128'(bus.in_ready), 128'(0));
            if (lat == 9) chk($sformatf("%s wait word", tag), 128'(core_dword_in), 128'(0));
            if (toggle) begin
                bus.in_valid = lat[0];
                bus.pt       = ~p ^ {4{i}};
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        bus.pt       = p;
        chk($sformatf("%s out_valid seen", tag), 128'(got), 128'(1));
        chk($sformatf("%s latency", tag), 128'(lat), 128'(15 + w));
        chk($sformatf("%s ct", tag), bus.ct, c);
        chk($sformatf("%s busy in OUT", tag), 128'(busy), 128'(1));
        for (int j = 0; j < 9; j++)
            chk($sformatf("%s load L%0d", tag, j), 128'(ld_w[j]), 128'(exp_load(p, k, j)));
        ct_seen = bus.ct;
        stable  = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.ct !== ct_seen) stable = 0;
        end
        chk($sformatf("%s held until out_ready", tag), 128'(stable), 128'(1));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("%s out_valid drop", tag), 128'(bus.out_valid), 128'(0));
        chk($sformatf("%s idle", tag), 128'(busy), 128'(0));
    endtask

    // Start a request and pulse reset low partway through it, at the cycle numbered 'at'.
    task automatic abort_req(input string tag, input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] c, input int at);
        wait_ready(tag);
        bus.pt = p; bus.key = k; core_ct = c; done_delay = 1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int lat = 0; lat < at; lat++) @(negedge clk);
        chk($sformatf("%s busy before reset", tag), 128'(busy), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        chk($sformatf("%s out_valid", tag), 128'(bus.out_valid), 128'(0));
        chk($sformatf("%s start_n", tag), 128'(core_start_n), 128'(1));
        chk($sformatf("%s start_read_n", tag), 128'(core_start_read_n), 128'(1));
        chk($sformatf("%s busy", tag), 128'(busy), 128'(0));
        chk($sformatf("%s in_ready in reset", tag), 128'(bus.in_ready), 128'(0));
        chk($sformatf("%s ct cleared", tag), bus.ct, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk($sformatf("%s in_ready after", tag), 128'(bus.in_ready), 128'(1));
    endtask

    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pt        = '0;
        bus.key       = '0;
        bus.out_ready = 1'b0;
        core_ct       = '0;
        done_delay    = 1;
        repeat (3) @(negedge clk);

        chk("rst in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst err", 128'(err), 128'(0));
        chk("rst start_n", 128'(core_start_n), 128'(1));
        chk("rst start_read_n", 128'(core_start_read_n), 128'(1));
        chk("rst dword_in", 128'(core_dword_in), 128'(0));
        chk("rst ct", bus.ct, 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 128'(bus.in_ready), 128'(1));

        do_req("fips197", PT1, KEY1, CT1, 3, 3, 4, 1'b0);
        do_req("appc1",   PT2, KEY2, CT2, 2, 2, 0, 1'b0);
        do_req("fastdone", PT1, KEY1, CT1, 0, 1, 1, 1'b0);
        do_req("toggle",  PT2, KEY2, CT2, 5, 5, 2, 1'b1);

        abort_req("rst_L4", PT1, KEY1, CT1, 4);
        abort_req("rst_R2", PT2, KEY2, CT2, 14);
        do_req("post_abort", PT1, KEY1, CT1, 1, 1, 1, 1'b0);

`ifdef AES_CTRL_TIMEOUT_EN
        begin
            int  err_cnt = 0;
            int  err_lat = -1;
            bit  ov_seen = 0;
            wait_ready("tmo");
            bus.pt = PT2; bus.key = KEY2; core_ct = CT2; done_delay = -1; bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            for (int lat = 0; lat < 60; lat++) begin
                if (err) begin
                    err_cnt++;
                    err_lat = lat;
                end
                if (bus.out_valid) ov_seen = 1;
                @(negedge clk);
            end
            chk("tmo err count", 128'(err_cnt), 128'(1));
            chk("tmo err cycle", 128'(err_lat), 128'(25));
            chk("tmo out_valid", 128'(ov_seen), 128'(0));
            chk("tmo idle", 128'(busy), 128'(0));
        end
`else
        chk("err tied low", 128'(err), 128'(0));
`endif

        chk("strobe overlap", 128'(strobe_clash), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
